// File: rtl/decode_scoreboard_if.sv
// Decode/scoreboard handshake bundle: issue request, writeback, flush in;
// stall, acknowledge and bypass selects out.
interface decode_scoreboard_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned LAT_W  = 3
);
  logic              issue_valid;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rs_used;
  logic              rt_used;
  logic              dst_we;
  logic [ADDR_W-1:0] dst_addr;
  logic [LAT_W-1:0]  dst_lat;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic              flush;
  logic              stall;
  logic              issue_ack;
  logic              fwd_rs;
  logic              fwd_rt;

  modport master (
    output issue_valid, rs_addr, rt_addr, rs_used, rt_used,
           dst_we, dst_addr, dst_lat, wb_valid, wb_addr, flush,
    input  stall, issue_ack, fwd_rs, fwd_rt
  );

  modport slave (
    input  issue_valid, rs_addr, rt_addr, rs_used, rt_used,
           dst_we, dst_addr, dst_lat, wb_valid, wb_addr, flush,
    output stall, issue_ack, fwd_rs, fwd_rt
  );
endinterface

// File: rtl/decode_scoreboard.sv
// Register scoreboard: per-register pending latency, hazard stall and bypass select.
// Optional macro SCOREBOARD_FWD_EN enables forwarding of results one cycle from ready.
module decode_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LAT_W    = 3
) (
  input logic               clk,
  input logic               rst,
  decode_scoreboard_if.slave sb
);

  localparam logic [LAT_W-1:0] HOLD = '1;

  logic [LAT_W-1:0] r_pend     [NUM_REGS];
  logic [LAT_W-1:0] w_pend_nxt [NUM_REGS];

  logic             w_rs_chk;
  logic             w_rt_chk;
  logic [LAT_W-1:0] w_rs_pend;
  logic [LAT_W-1:0] w_rt_pend;
  logic             w_rs_haz;
  logic             w_rt_haz;
  logic             w_stall;
  logic             w_ack;
  logic             w_load;

  // Register 0 and out-of-range addresses read as "never pending".
  assign w_rs_chk  = sb.rs_used && (sb.rs_addr != '0) && (32'(sb.rs_addr) < NUM_REGS);
  assign w_rt_chk  = sb.rt_used && (sb.rt_addr != '0) && (32'(sb.rt_addr) < NUM_REGS);
  assign w_rs_pend = w_rs_chk ? r_pend[sb.rs_addr] : '0;
  assign w_rt_pend = w_rt_chk ? r_pend[sb.rt_addr] : '0;

`ifdef SCOREBOARD_FWD_EN
  assign w_rs_haz  = w_rs_pend > LAT_W'(1);
  assign w_rt_haz  = w_rt_pend > LAT_W'(1);
  assign sb.fwd_rs = w_rs_pend == LAT_W'(1);
  assign sb.fwd_rt = w_rt_pend == LAT_W'(1);
`else
  assign w_rs_haz  = w_rs_pend != '0;
  assign w_rt_haz  = w_rt_pend != '0;
  assign sb.fwd_rs = 1'b0;
  assign sb.fwd_rt = 1'b0;
`endif

  assign w_stall      = sb.issue_valid && (w_rs_haz || w_rt_haz);
  assign w_ack        = sb.issue_valid && !w_stall && !sb.flush;
  assign w_load       = w_ack && sb.dst_we;
  assign sb.stall     = w_stall;
  assign sb.issue_ack = w_ack;

  // Priority per entry: flush > issue load > writeback clear > countdown.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      w_pend_nxt[i] = r_pend[i];
      if (i != 0) begin
        if ((r_pend[i] != '0) && (r_pend[i] != HOLD))
          w_pend_nxt[i] = r_pend[i] - LAT_W'(1);
        if (sb.wb_valid && (sb.wb_addr == ADDR_W'(i)))
          w_pend_nxt[i] = '0;
        if (w_load && (sb.dst_addr == ADDR_W'(i)))
          w_pend_nxt[i] = sb.dst_lat;
      end
      if (sb.flush)
        w_pend_nxt[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        r_pend[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        r_pend[i] <= w_pend_nxt[i];
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard: directed table, corner sequences, random vs model.
module tb_decode_scoreboard;

  localparam int NR   = 32;
  localparam int AW   = 5;
  localparam int LW   = 3;
  localparam int HOLD = 7;
`ifdef SCOREBOARD_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif
  localparam int T = FWD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_scoreboard_if #(.ADDR_W(AW), .LAT_W(LW)) ifc ();

  decode_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .LAT_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (ifc.slave)
  );

  int pend_m [NR];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int iv, rsu, rs, rtu, rt, we, dst, lat, wbv, wb, fl;
    int e_stall, e_ack, e_frs, e_frt;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(string nm, logic act, int exp);
    n_cmp++;
    if (act !== 1'(exp)) begin
      n_err++;
      $display("FAIL %s: got %b expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(int iv, int rsu, int rs, int rtu, int rt, int we, int dst,
                       int lat, int wbv, int wb, int fl);
    ifc.issue_valid = 1'(iv);
    ifc.rs_used     = 1'(rsu);
    ifc.rs_addr     = AW'(rs);
    ifc.rt_used     = 1'(rtu);
    ifc.rt_addr     = AW'(rt);
    ifc.dst_we      = 1'(we);
    ifc.dst_addr    = AW'(dst);
    ifc.dst_lat     = LW'(lat);
    ifc.wb_valid    = 1'(wbv);
    ifc.wb_addr     = AW'(wb);
    ifc.flush       = 1'(fl);
  endtask

  // Remaining cycles a source must wait for; unused, $0 and out-of-range never wait.
  function automatic int src_pend(logic used, logic [AW-1:0] a);
    if (!used || a == 0 || int'(a) >= NR) return 0;
    return pend_m[int'(a)];
  endfunction

  function automatic int m_stall();
    return (ifc.issue_valid && (src_pend(ifc.rs_used, ifc.rs_addr) > T ||
                                src_pend(ifc.rt_used, ifc.rt_addr) > T)) ? 1 : 0;
  endfunction

  function automatic int m_ack();
    return (ifc.issue_valid && m_stall() == 0 && !ifc.flush) ? 1 : 0;
  endfunction

  function automatic int m_fwd(logic used, logic [AW-1:0] a);
    return (FWD == 1 && src_pend(used, a) == 1) ? 1 : 0;
  endfunction

  task automatic check_model(string tag);
    chk($sformatf("%s.stall", tag),  ifc.stall,     m_stall());
    chk($sformatf("%s.ack", tag),    ifc.issue_ack, m_ack());
    chk($sformatf("%s.fwd_rs", tag), ifc.fwd_rs,    m_fwd(ifc.rs_used, ifc.rs_addr));
    chk($sformatf("%s.fwd_rt", tag), ifc.fwd_rt,    m_fwd(ifc.rt_used, ifc.rt_addr));
  endtask

  task automatic tick();
    int nxt [NR];
    int ack;
    if (rst || ifc.flush) begin
      foreach (pend_m[r]) pend_m[r] = 0;
    end else begin
      ack = m_ack();
      foreach (pend_m[r]) nxt[r] = (pend_m[r] > 0 && pend_m[r] < HOLD) ? pend_m[r] - 1 : pend_m[r];
      if (ifc.wb_valid && ifc.wb_addr != 0 && int'(ifc.wb_addr) < NR)
        nxt[int'(ifc.wb_addr)] = 0;
      if (ack == 1 && ifc.dst_we && ifc.dst_addr != 0 && int'(ifc.dst_addr) < NR)
        nxt[int'(ifc.dst_addr)] = int'(ifc.dst_lat);
      pend_m = nxt;
    end
  endtask

  task automatic cycle(string tag);
    @(negedge clk);
    check_model(tag);
    @(posedge clk);
    tick();
    #1;
  endtask

  task automatic cyc_exp(string tag, int es, int ea);
    @(negedge clk);
    chk($sformatf("%s.stall_exp", tag), ifc.stall, es);
    chk($sformatf("%s.ack_exp", tag), ifc.issue_ack, ea);
    check_model(tag);
    @(posedge clk);
    tick();
    #1;
  endtask

  initial begin
    foreach (pend_m[r]) pend_m[r] = 0;
    rst = 1'b1;
    drive(1, 1, 3, 1, 5, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc_exp("reset", 0, 1);
    rst = 1'b0;

    //                iv rsu rs rtu rt we dst lat wbv wb fl   stall    ack    frs    frt
    tbl.push_back('{1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0,   0,       1,     0,     0});
    tbl.push_back('{1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,   1 - FWD, FWD,   FWD,   0});
    tbl.push_back('{1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,   0,       1,     0,     0});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0,   0,       1,     0,     0});
    tbl.push_back('{1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0,   1,       0,     0,     0});
    tbl.push_back('{1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0,   1 - FWD, FWD,   0,     FWD});
    tbl.push_back('{1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0,   0,       1,     0,     0});
    tbl.push_back('{1, 1, 0, 0, 0, 1, 0, 3, 0, 0, 0,   0,       1,     0,     0});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 6, 3, 0, 0, 0,   0,       1,     0,     0});
    tbl.push_back('{1, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0,   0,       1,     0,     0});
    tbl.push_back('{0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0,   0,       0,     0,     0});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 9, 3, 0, 0, 1,   0,       0,     0,     0});
    tbl.push_back('{1, 1, 9, 1, 6, 0, 0, 0, 0, 0, 0,   0,       1,     0,     0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].rsu, tbl[i].rs, tbl[i].rtu, tbl[i].rt, tbl[i].we,
            tbl[i].dst, tbl[i].lat, tbl[i].wbv, tbl[i].wb, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("tbl%0d.stall", i),  ifc.stall,     tbl[i].e_stall);
      chk($sformatf("tbl%0d.ack", i),    ifc.issue_ack, tbl[i].e_ack);
      chk($sformatf("tbl%0d.fwd_rs", i), ifc.fwd_rs,    tbl[i].e_frs);
      chk($sformatf("tbl%0d.fwd_rt", i), ifc.fwd_rt,    tbl[i].e_frt);
      check_model($sformatf("tbl%0d", i));
      @(posedge clk);
      tick();
      #1;
    end

    // Variable-latency producer blocks its consumer until writeback.
    drive(1, 0, 0, 0, 0, 1, 7, HOLD, 0, 0, 0);
    cyc_exp("hold_issue", 0, 1);
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) cyc_exp("hold_stall", 1, 0);
    drive(1, 1, 7, 0, 0, 0, 0, 0, 1, 7, 0);
    cyc_exp("hold_wb", 1, 0);
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc_exp("hold_release", 0, 1);

    // Flush squashes the pending $4 and the concurrent issue to $9.
    drive(1, 0, 0, 0, 0, 1, 4, 3, 0, 0, 0);
    cyc_exp("flush_load", 0, 1);
    drive(1, 0, 0, 0, 0, 1, 9, 3, 0, 0, 1);
    cyc_exp("flush_cycle", 0, 0);
    drive(1, 1, 4, 1, 9, 0, 0, 0, 0, 0, 0);
    cyc_exp("flush_after", 0, 1);

    // Issue load beats same-cycle writeback; async reset releases stall immediately.
    drive(1, 0, 0, 0, 0, 1, 2, 3, 1, 2, 0);
    cyc_exp("race_issue", 0, 1);
    drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc_exp("race_stall", 1, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst.stall", ifc.stall, 0);
    chk("async_rst.ack", ifc.issue_ack, 1);
    foreach (pend_m[r]) pend_m[r] = 0;
    #1 rst = 1'b0;
    cyc_exp("post_rst", 0, 1);

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 3) != 0) ? 1 : 0,
            int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(1, HOLD)),
            ($urandom_range(0, 2) == 0) ? 1 : 0, int'($urandom_range(0, 7)),
            ($urandom_range(0, 19) == 0) ? 1 : 0);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
